// File: rtl/decoder.sv
// ---------------------------------------------------------------------------
// decoder
//
// Binary-to-one-hot decoder. A WIDTH-bit index N lights exactly one bit of
// the 2**WIDTH-bit output `result`, purely combinationally. An optional
// register stage, enabled by defining the macro DECODER_REG_OUT_EN, provides
// a one-cycle-delayed copy of the decode plus a pulse whenever the sampled
// index changes.
//
// Configuration macro: DECODER_REG_OUT_EN
//   defined   -> result_q / change are registered on clk, reset is used
//   undefined -> no flops; result_q and change are tied to 0 and
//                clk / reset are unused
//
// Parameters:
//   WIDTH       index width in bits (1..8)
//   OUT_W       2**WIDTH, derived output width (not meant to be overridden)
//
// Ports:
//   clk         rising-edge clock for the register stage
//   reset       asynchronous active-low reset for every flop
//   N           binary index to decode
//   result      combinational one-hot decode of N
//   result_q    `result` registered on clk (all zeros in reset)
//   change      one-cycle pulse when the sampled index differs from the
//               previously sampled index
//   onehot_err  combinational self-check, 1 if `result` is not one-hot
// ---------------------------------------------------------------------------
module decoder #(
    parameter int WIDTH = 3,
    parameter int OUT_W = 2 ** WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] N,
    output logic [OUT_W-1:0] result,
    output logic [OUT_W-1:0] result_q,
    output logic             change,
    output logic             onehot_err
);

    localparam logic [OUT_W-1:0] ONE_HOT_LSB = OUT_W'(1);
    localparam logic [WIDTH:0]   ONE_COUNT   = (WIDTH + 1)'(1);

    logic [WIDTH:0] onesCount;

    // The decode: shift a single set bit up to position N. An X/Z index
    // yields an all-X result in simulation, which is acceptable.
    always_comb begin
        result = ONE_HOT_LSB << N;
    end

    // Popcount of the decode. A correct decoder always produces exactly one
    // set bit, so synthesis folds this to a constant 0; it is kept as a
    // simulation-visible sanity flag.
    always_comb begin
        onesCount = '0;
        for (int i = 0; i < OUT_W; i++) begin
            onesCount = onesCount + {{WIDTH{1'b0}}, result[i]};
        end
        onehot_err = (onesCount != ONE_COUNT);
    end

`ifdef DECODER_REG_OUT_EN

    logic [WIDTH-1:0] n_q;
    logic [WIDTH-1:0] n_d;
    logic             primed_q;
    logic             change_d;

    // primed_q marks that at least one index has been sampled since reset.
    // Without it, the first sampled edge would compare against the reset
    // value of n_q and could falsely report a change.
    always_comb begin
        n_d      = N;
        change_d = primed_q && (N != n_q);
    end

    // Register stage: delayed decode, last sampled index and change pulse.
    // Reset clears result_q to all zeros, deliberately not a one-hot value,
    // so consumers see no slot selected while in reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_q <= '0;
            n_q      <= '0;
            primed_q <= 1'b0;
            change   <= 1'b0;
        end else begin
            result_q <= result;
            n_q      <= n_d;
            primed_q <= 1'b1;
            change   <= change_d;
        end
    end

`else

    logic unusedSinks;

    // No register stage in this build: the delayed outputs are constant and
    // the clock/reset pins are only absorbed here.
    assign result_q    = '0;
    assign change      = 1'b0;
    assign unusedSinks = &{1'b0, clk, reset};

`endif

endmodule

// File: tb/tb_decoder.sv
// ---------------------------------------------------------------------------
// tb_decoder
//
// Self-checking bench for decoder. A WIDTH=3 instance is exercised with a
// table-driven sweep, hand-written reset/ordering sequences and randomized
// indices; a WIDTH=4 instance checks the wider decode. Expected values come
// from a behavioural model that works from plain arithmetic (2**N, a
// remembered previous index, a flag for "sampled since reset").
// Register-stage expectations apply when DECODER_REG_OUT_EN is defined;
// otherwise result_q and change are expected to stay at 0.
// ---------------------------------------------------------------------------
module tb_decoder;

`ifdef DECODER_REG_OUT_EN
    localparam bit REG_EN = 1'b1;
`else
    localparam bit REG_EN = 1'b0;
`endif

    typedef struct {
        logic [2:0] n;
        logic [7:0] expResult;
        logic       expErr;
    } vector_t;

    logic        clk;
    logic        reset;
    logic [2:0]  nIn;
    logic [7:0]  result;
    logic [7:0]  resultQ;
    logic        change;
    logic        onehotErr;

    logic [3:0]  nIn4;
    logic [15:0] result4;
    logic [15:0] resultQ4;
    logic        change4;
    logic        onehotErr4;

    int          assertCount;
    int          failCount;

    // Behavioural model of the register stage
    logic [7:0]  mResultQ;
    logic        mChange;
    int          mPrevN;
    bit          mSampled;

    vector_t     sweep[9];

    decoder #(.WIDTH(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .N          (nIn),
        .result     (result),
        .result_q   (resultQ),
        .change     (change),
        .onehot_err (onehotErr)
    );

    decoder #(.WIDTH(4)) dut4 (
        .clk        (clk),
        .reset      (reset),
        .N          (nIn4),
        .result     (result4),
        .result_q   (resultQ4),
        .change     (change4),
        .onehot_err (onehotErr4)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison; X/Z on the actual value counts as a failure
    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive a new index away from the active edge
    task automatic applyStimulus(input logic [2:0] n);
        @(negedge clk);
        nIn = n;
        #1;
    endtask

    // Model reaction to reset assertion: immediate clear
    task automatic modelReset();
        mResultQ = 8'h00;
        mChange  = 1'b0;
        mPrevN   = 0;
        mSampled = 0;
    endtask

    // Advance one rising edge, update the model, then sample just after it
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            mChange  = mSampled && (int'(nIn) != mPrevN);
            mResultQ = 8'(2 ** int'(nIn));
            mPrevN   = int'(nIn);
            mSampled = 1;
        end
        #1;
    endtask

    task automatic checkComb(input string tag);
        checkOutput({tag, ".result"}, {8'h00, result}, {8'h00, 8'(2 ** int'(nIn))});
        checkOutput({tag, ".onehot_err"}, {15'h0, onehotErr}, 16'h0);
    endtask

    task automatic checkRegs(input string tag);
        checkOutput({tag, ".result_q"}, {8'h00, resultQ}, REG_EN ? {8'h00, mResultQ} : 16'h0);
        checkOutput({tag, ".change"}, {15'h0, change}, REG_EN ? {15'h0, mChange} : 16'h0);
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        modelReset();

        // Sweep table written out literally, ending with the wrap to 0
        sweep[0] = '{3'd0, 8'b00000001, 1'b0};
        sweep[1] = '{3'd1, 8'b00000010, 1'b0};
        sweep[2] = '{3'd2, 8'b00000100, 1'b0};
        sweep[3] = '{3'd3, 8'b00001000, 1'b0};
        sweep[4] = '{3'd4, 8'b00010000, 1'b0};
        sweep[5] = '{3'd5, 8'b00100000, 1'b0};
        sweep[6] = '{3'd6, 8'b01000000, 1'b0};
        sweep[7] = '{3'd7, 8'b10000000, 1'b0};
        sweep[8] = '{3'd0, 8'b00000001, 1'b0};

        // Reset state; the combinational decode is live during reset
        reset = 1'b0;
        nIn   = 3'd0;
        nIn4  = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.result_q", {8'h00, resultQ}, 16'h0);
        checkOutput("reset.change", {15'h0, change}, 16'h0);
        checkOutput("reset.result", {8'h00, result}, 16'h0001);

        // Table-driven sweep, one index per clock
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(sweep[i].n);
            checkOutput($sformatf("sweep%0d.result", i), {8'h00, result}, {8'h00, sweep[i].expResult});
            checkOutput($sformatf("sweep%0d.err", i), {15'h0, onehotErr}, {15'h0, sweep[i].expErr});
            tick();
            checkRegs($sformatf("sweep%0d", i));
        end
        // The wrap 7 -> 0 must have pulsed change with result_q at bit 0
        if (REG_EN) begin
            checkOutput("wrap.change", {15'h0, change}, 16'h1);
            checkOutput("wrap.result_q", {8'h00, resultQ}, 16'h0001);
        end
        // Index held: change must fall on the next edge
        tick();
        checkRegs("hold0");

        // Combinational decode with no clock edge in between
        @(negedge clk);
        nIn = 3'd5;
        #1;
        checkOutput("comb5.result", {8'h00, result}, 16'h0020);
        nIn = 3'd2;
        #1;
        checkOutput("comb2.result", {8'h00, result}, 16'h0004);
        tick();
        checkRegs("comb2");

        // Reset, then release together with a new index: first edge loads
        // result_q but change stays low, and stays low while N is steady
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        #1;
        checkRegs("rst2");
        @(negedge clk);
        reset = 1'b1;
        nIn   = 3'd3;
        tick();
        checkRegs("release3");
        if (REG_EN) begin
            checkOutput("release3.result_q_lit", {8'h00, resultQ}, 16'h0008);
        end
        tick();
        checkRegs("steady3");

        // Reset mid-operation clears registers without an edge
        applyStimulus(3'd7);
        tick();
        checkRegs("pre_rst7");
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        #1;
        checkOutput("midrst.result_q", {8'h00, resultQ}, 16'h0);
        checkOutput("midrst.change", {15'h0, change}, 16'h0);
        checkOutput("midrst.result", {8'h00, result}, 16'h0080);
        nIn = 3'd1;
        #1;
        checkOutput("midrst.track", {8'h00, result}, 16'h0002);

        // Randomized indices, with frequent repeats and the odd reset pulse
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 2) != 0) begin
                applyStimulus(3'($urandom_range(0, 7)));
            end else begin
                applyStimulus(nIn);
            end
            checkComb($sformatf("rand%0d", k));
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b0;
                modelReset();
                #1;
                checkRegs($sformatf("rand%0d.rst", k));
                @(negedge clk);
                reset = 1'b1;
            end
            tick();
            checkRegs($sformatf("rand%0d", k));
        end

        // Wider instance: boundary indices, then random ones
        nIn4 = 4'd15;
        #1;
        checkOutput("w4.n15", result4, 16'h8000);
        checkOutput("w4.n15.err", {15'h0, onehotErr4}, 16'h0);
        nIn4 = 4'd0;
        #1;
        checkOutput("w4.n0", result4, 16'h0001);
        for (int k = 0; k < 20; k++) begin
            nIn4 = 4'($urandom_range(0, 15));
            #1;
            checkOutput($sformatf("w4.rand%0d", k), result4, 16'(2 ** int'(nIn4)));
            checkOutput($sformatf("w4.rand%0d.err", k), {15'h0, onehotErr4}, 16'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
